// File: rtl/pipe_rca_pkg.sv
// rtl/pipe_rca_pkg.sv - stage record and stage-count helper for pipe_rca_adder
// The msb_cin field exists only when PIPE_RCA_ADDER_OVF_EN is defined.
package pipe_rca_pkg;
    localparam int MAX_WIDTH = 128;

    function automatic int calc_nstage(input int width, input int seg_width);
        return (width + seg_width - 1) / seg_width;
    endfunction

    // Fields are sized for the widest legal operand; bits above WIDTH stay zero.
    typedef struct packed {
        logic                 valid;
        logic                 carry;
`ifdef PIPE_RCA_ADDER_OVF_EN
        logic                 msb_cin;
`endif
        logic [MAX_WIDTH-1:0] sum;
        logic [MAX_WIDTH-1:0] a;
        logic [MAX_WIDTH-1:0] b;
    } stage_t;
endpackage

// File: rtl/pipe_rca_adder_if.sv
// rtl/pipe_rca_adder_if.sv - operand/result handshake bundle for pipe_rca_adder
// o_ovf is present only when PIPE_RCA_ADDER_OVF_EN is defined.
interface pipe_rca_adder_if #(
    parameter int WIDTH = 30
);
    logic             i_valid;
    logic             o_ready;
    logic [WIDTH-1:0] i_add_term1;
    logic [WIDTH-1:0] i_add_term2;
    logic             i_sub;
    logic             o_valid;
    logic             i_ready;
    logic [WIDTH:0]   o_result;
`ifdef PIPE_RCA_ADDER_OVF_EN
    logic             o_ovf;

    modport master (
        output i_valid, i_add_term1, i_add_term2, i_sub, i_ready,
        input  o_ready, o_valid, o_result, o_ovf
    );
    modport slave (
        input  i_valid, i_add_term1, i_add_term2, i_sub, i_ready,
        output o_ready, o_valid, o_result, o_ovf
    );
`else
    modport master (
        output i_valid, i_add_term1, i_add_term2, i_sub, i_ready,
        input  o_ready, o_valid, o_result
    );
    modport slave (
        input  i_valid, i_add_term1, i_add_term2, i_sub, i_ready,
        output o_ready, o_valid, o_result
    );
`endif
endinterface

// File: rtl/full_adder.sv
// rtl/full_adder.sv - single-bit full adder cell
module full_adder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic cout
);
    assign sum  = a ^ b ^ cin;
    assign cout = (a & b) | (cin & (a ^ b));
endmodule

// File: rtl/rca_segment.sv
// rtl/rca_segment.sv - combinational ripple-carry segment built from full_adder cells
module rca_segment #(
    parameter int SEG_WIDTH = 8
) (
    input  logic [SEG_WIDTH-1:0] a,
    input  logic [SEG_WIDTH-1:0] b,
    input  logic                 cin,
    output logic [SEG_WIDTH-1:0] sum,
    output logic                 cout,
    output logic                 msb_cin
);
    logic [SEG_WIDTH:0] c;

    assign c[0] = cin;

    for (genvar i = 0; i < SEG_WIDTH; i++) begin : g_bit
        full_adder u_fa (
            .a    (a[i]),
            .b    (b[i]),
            .cin  (c[i]),
            .sum  (sum[i]),
            .cout (c[i+1])
        );
    end

    assign cout    = c[SEG_WIDTH];
    assign msb_cin = c[SEG_WIDTH-1];
endmodule

// File: rtl/pipe_rca_adder.sv
// rtl/pipe_rca_adder.sv - pipelined ripple-carry adder/subtractor, one registered segment per stage
// Defining PIPE_RCA_ADDER_OVF_EN adds the signed-overflow output o_ovf.
module pipe_rca_adder
    import pipe_rca_pkg::*;
#(
    parameter int WIDTH     = 30,
    parameter int SEG_WIDTH = 8
) (
    input  logic            i_clk,
    input  logic            i_rst,
    pipe_rca_adder_if.slave bus
);
    localparam int NSTAGE = calc_nstage(WIDTH, SEG_WIDTH);

    logic   advance;
    logic   out_valid;
    stage_t in_rec;
    stage_t out_rec;
    stage_t st_q [NSTAGE];

    // Subtraction folds into the add: B is inverted here and the +1 enters as segment 0's carry-in.
    always_comb begin
        in_rec               = '0;
        in_rec.valid         = bus.i_valid;
        in_rec.carry         = bus.i_sub;
        in_rec.a[WIDTH-1:0]  = bus.i_add_term1;
        in_rec.b[WIDTH-1:0]  = bus.i_sub ? ~bus.i_add_term2 : bus.i_add_term2;
    end

    for (genvar k = 0; k < NSTAGE; k++) begin : g_stage
        localparam int LO = k * SEG_WIDTH;
        localparam int SW = ((WIDTH - LO) < SEG_WIDTH) ? (WIDTH - LO) : SEG_WIDTH;

        stage_t        src;
        stage_t        st_d;
        logic [SW-1:0] seg_sum;
        logic          seg_cout;
        logic          seg_msb_cin;

        if (k == 0) begin : g_src_in
            assign src = in_rec;
        end else begin : g_src_prev
            assign src = st_q[k-1];
        end

        rca_segment #(.SEG_WIDTH(SW)) u_seg (
            .a       (src.a[LO +: SW]),
            .b       (src.b[LO +: SW]),
            .cin     (src.carry),
            .sum     (seg_sum),
            .cout    (seg_cout),
            .msb_cin (seg_msb_cin)
        );

        always_comb begin
            st_d                = src;
            st_d.sum[LO +: SW]  = seg_sum;
            st_d.carry          = seg_cout;
`ifdef PIPE_RCA_ADDER_OVF_EN
            st_d.msb_cin        = seg_msb_cin;
`endif
        end

`ifndef PIPE_RCA_ADDER_OVF_EN
        logic unused_msb;
        assign unused_msb = seg_msb_cin;
`endif

        // The whole pipe moves as one; a bubble simply carries valid=0 forward.
        always_ff @(posedge i_clk) begin
            if (i_rst) begin
                st_q[k] <= '0;
            end else if (advance) begin
                st_q[k] <= st_d;
            end
        end
    end

    assign out_rec      = st_q[NSTAGE-1];
    assign out_valid    = out_rec.valid & ~i_rst;
    assign bus.o_valid  = out_valid;
    assign bus.o_ready  = ~out_valid | bus.i_ready;
    assign advance      = bus.o_ready;
    assign bus.o_result = i_rst ? '0 : {out_rec.carry, out_rec.sum[WIDTH-1:0]};

`ifdef PIPE_RCA_ADDER_OVF_EN
    assign bus.o_ovf = ~i_rst & (out_rec.msb_cin ^ out_rec.carry);
`endif

    logic unused_out;
    assign unused_out = ^{out_rec.a, out_rec.b, out_rec.sum};
endmodule

// File: tb/tb_pipe_rca_adder.sv
// tb/tb_pipe_rca_adder.sv - self-checking bench for pipe_rca_adder (o_ovf checks under PIPE_RCA_ADDER_OVF_EN)
module tb_pipe_rca_adder;
    localparam int W         = 30;
    localparam int SWEEP_CYC = 5000;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_err = 0;
    int   n_checks = 0;
    int   sweep_ops = 0;
    int   sweep_done = 0;
    logic sweep_go = 1'b0;

    always #5 clk = ~clk;

    pipe_rca_adder_if #(.WIDTH(W)) mif ();
    pipe_rca_adder #(.WIDTH(W), .SEG_WIDTH(8)) u_dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (mif)
    );

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         sub;
        logic [W:0]   res;
        logic         ovf;
    } vec_t;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
        end
    endtask

    task automatic fail_now(input string name);
        n_checks++;
        n_err++;
        $display("FAIL %s: unexpected result, none pending", name);
    endtask

    // {ovf, carry, sum} from plain integer arithmetic and the operand-sign overflow rule.
    function automatic logic [W+1:0] model(input logic [W-1:0] a, input logic [W-1:0] b, input logic s);
        logic [W-1:0] be;
        logic [W:0]   r;
        logic         ov;
        be = s ? ~b : b;
        r  = {1'b0, a} + {1'b0, be} + {{W{1'b0}}, s};
        ov = (a[W-1] == be[W-1]) && (r[W-1] != a[W-1]);
        return {ov, r};
    endfunction

    function automatic logic [W-1:0] rnd30();
        logic [31:0] r;
        r = $urandom();
        case ($urandom_range(7))
            0:       return '0;
            1:       return '1;
            2:       return {1'b1, {(W-1){1'b0}}};
            default: return r[W-1:0];
        endcase
    endfunction

    for (genvar g = 0; g < 3; g++) begin : g_sweep
        localparam int SW = (g == 0) ? 1 : ((g == 1) ? 7 : 30);

        pipe_rca_adder_if #(.WIDTH(W)) sif ();
        pipe_rca_adder #(.WIDTH(W), .SEG_WIDTH(SW)) u_sdut (
            .i_clk (clk),
            .i_rst (rst),
            .bus   (sif)
        );

        logic [W+1:0] q[$];

        initial begin
            sif.i_valid     = 1'b0;
            sif.i_ready     = 1'b1;
            sif.i_sub       = 1'b0;
            sif.i_add_term1 = '0;
            sif.i_add_term2 = '0;
            wait (sweep_go);
            repeat (SWEEP_CYC) begin
                @(posedge clk);
                #1;
                sif.i_valid     = ($urandom_range(7) != 0);
                sif.i_ready     = ($urandom_range(7) != 0);
                sif.i_sub       = 1'($urandom_range(1));
                sif.i_add_term1 = rnd30();
                sif.i_add_term2 = rnd30();
            end
            @(posedge clk);
            #1;
            sif.i_valid = 1'b0;
            sif.i_ready = 1'b1;
            repeat (40) @(posedge clk);
            @(negedge clk);
            check($sformatf("sweep_drain_seg%0d", SW), 64'(q.size()), 64'd0);
            sweep_done++;
        end

        always @(negedge clk) begin : mon
            logic [W+1:0] e;
            if (rst) begin
                q.delete();
            end else begin
                if (sif.o_valid && sif.i_ready) begin
                    if (q.size() == 0) begin
                        fail_now($sformatf("sweep_extra_seg%0d", SW));
                    end else begin
                        e = q.pop_front();
                        check($sformatf("sweep_result_seg%0d", SW), 64'(sif.o_result), 64'(e[W:0]));
`ifdef PIPE_RCA_ADDER_OVF_EN
                        check($sformatf("sweep_ovf_seg%0d", SW), 64'(sif.o_ovf), 64'(e[W+1]));
`endif
                    end
                end
                if (sif.i_valid && sif.o_ready) begin
                    q.push_back(model(sif.i_add_term1, sif.i_add_term2, sif.i_sub));
                    sweep_ops++;
                end
            end
        end
    end

    initial begin
        vec_t         vt [11];
        logic [W-1:0] bp_a [10];
        logic [W-1:0] bp_b [10];
        logic         bp_s [10];
        logic [W+1:0] bpq[$];
        logic [W+1:0] e;
        logic [W:0]   held;
        int           lat;
        int           idx;
        int           cyc;
        int           delivered;
        int           seen;
        logic         stalled_prev;
        logic         stalled_now;
        logic         accepted;

        vt[0]  = '{a: 30'h3FFFFFFF, b: 30'h3FFFFFFF, sub: 1'b0, res: 31'h7FFFFFFE, ovf: 1'b0};
        vt[1]  = '{a: 30'h00000005, b: 30'h00000003, sub: 1'b1, res: 31'h40000002, ovf: 1'b0};
        vt[2]  = '{a: 30'h00000003, b: 30'h00000005, sub: 1'b1, res: 31'h3FFFFFFE, ovf: 1'b0};
        vt[3]  = '{a: 30'h00000000, b: 30'h00000000, sub: 1'b0, res: 31'h00000000, ovf: 1'b0};
        vt[4]  = '{a: 30'h000000FF, b: 30'h00000001, sub: 1'b0, res: 31'h00000100, ovf: 1'b0};
        vt[5]  = '{a: 30'h00FFFFFF, b: 30'h00000001, sub: 1'b0, res: 31'h01000000, ovf: 1'b0};
        vt[6]  = '{a: 30'h00000000, b: 30'h00000000, sub: 1'b1, res: 31'h40000000, ovf: 1'b0};
        vt[7]  = '{a: 30'h12345678, b: 30'h0EDCBA98, sub: 1'b0, res: 31'h21111110, ovf: 1'b1};
        vt[8]  = '{a: 30'h1FFFFFFF, b: 30'h00000001, sub: 1'b0, res: 31'h20000000, ovf: 1'b1};
        vt[9]  = '{a: 30'h20000000, b: 30'h00000001, sub: 1'b1, res: 31'h5FFFFFFF, ovf: 1'b1};
        vt[10] = '{a: 30'h00000000, b: 30'h00000001, sub: 1'b1, res: 31'h3FFFFFFF, ovf: 1'b0};

        mif.i_valid     = 1'b0;
        mif.i_ready     = 1'b1;
        mif.i_sub       = 1'b0;
        mif.i_add_term1 = '0;
        mif.i_add_term2 = '0;

        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset_valid", 64'(mif.o_valid), 64'd0);
        check("reset_result", 64'(mif.o_result), 64'd0);
`ifdef PIPE_RCA_ADDER_OVF_EN
        check("reset_ovf", 64'(mif.o_ovf), 64'd0);
`endif
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("ready_after_reset", 64'(mif.o_ready), 64'd1);

        for (int i = 0; i < 11; i++) begin
            @(posedge clk);
            #1;
            mif.i_valid     = 1'b1;
            mif.i_add_term1 = vt[i].a;
            mif.i_add_term2 = vt[i].b;
            mif.i_sub       = vt[i].sub;
            @(posedge clk);
            #1;
            mif.i_valid = 1'b0;
            lat = 0;
            do begin
                @(negedge clk);
                lat++;
            end while (!mif.o_valid && lat < 20);
            check($sformatf("vec%0d_latency", i), 64'(lat), 64'd4);
            check($sformatf("vec%0d_result", i), 64'(mif.o_result), 64'(vt[i].res));
`ifdef PIPE_RCA_ADDER_OVF_EN
            check($sformatf("vec%0d_ovf", i), 64'(mif.o_ovf), 64'(vt[i].ovf));
`endif
        end

        // Back-to-back stream with the sink stalled during cycles 3..7.
        for (int i = 0; i < 10; i++) begin
            bp_a[i] = rnd30();
            bp_b[i] = rnd30();
            bp_s[i] = 1'($urandom_range(1));
        end
        idx          = 0;
        cyc          = 0;
        delivered    = 0;
        stalled_prev = 1'b0;
        held         = '0;
        @(posedge clk);
        #1;
        mif.i_valid     = 1'b1;
        mif.i_add_term1 = bp_a[0];
        mif.i_add_term2 = bp_b[0];
        mif.i_sub       = bp_s[0];
        mif.i_ready     = 1'b1;
        while (cyc < 60) begin
            @(negedge clk);
            if (stalled_prev) begin
                check("bp_hold_valid", 64'(mif.o_valid), 64'd1);
                check("bp_hold_result", 64'(mif.o_result), 64'(held));
            end
            stalled_now = mif.o_valid && !mif.i_ready;
            if (stalled_now) begin
                check("bp_ready_low", 64'(mif.o_ready), 64'd0);
                if (!stalled_prev) held = mif.o_result;
            end
            if (mif.o_valid && mif.i_ready) begin
                if (bpq.size() == 0) begin
                    fail_now("bp_extra");
                end else begin
                    e = bpq.pop_front();
                    check($sformatf("bp_result%0d", delivered), 64'(mif.o_result), 64'(e[W:0]));
`ifdef PIPE_RCA_ADDER_OVF_EN
                    check($sformatf("bp_ovf%0d", delivered), 64'(mif.o_ovf), 64'(e[W+1]));
`endif
                end
                delivered++;
            end
            accepted = mif.i_valid && mif.o_ready;
            if (accepted) bpq.push_back(model(mif.i_add_term1, mif.i_add_term2, mif.i_sub));
            stalled_prev = stalled_now;
            @(posedge clk);
            #1;
            if (accepted) idx++;
            cyc++;
            mif.i_valid = (idx < 10);
            if (idx < 10) begin
                mif.i_add_term1 = bp_a[idx];
                mif.i_add_term2 = bp_b[idx];
                mif.i_sub       = bp_s[idx];
            end
            mif.i_ready = !(cyc >= 3 && cyc <= 7);
        end
        check("bp_delivered", 64'(delivered), 64'd10);
        check("bp_pending", 64'(bpq.size()), 64'd0);

        // Three ops in flight, then a one-cycle reset.
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            mif.i_valid     = 1'b1;
            mif.i_add_term1 = 30'(i + 1);
            mif.i_add_term2 = 30'h100;
            mif.i_sub       = 1'b0;
        end
        @(posedge clk);
        #1;
        mif.i_valid = 1'b0;
        rst         = 1'b1;
        @(negedge clk);
        check("rst_during_valid", 64'(mif.o_valid), 64'd0);
        check("rst_during_result", 64'(mif.o_result), 64'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("rst_after_valid", 64'(mif.o_valid), 64'd0);
        check("rst_after_result", 64'(mif.o_result), 64'd0);
        check("rst_after_ready", 64'(mif.o_ready), 64'd1);
        seen = 0;
        repeat (12) begin
            @(negedge clk);
            if (mif.o_valid) seen++;
        end
        check("rst_no_stale", 64'(seen), 64'd0);

        sweep_go = 1'b1;
        wait (sweep_done == 3);
        check("sweep_op_count", 64'(sweep_ops >= 10000), 64'd1);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end
endmodule
